// File: rtl/reset_ctrl_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int                   LOSS_CNT_W   = 4;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 4'd15;

endpackage

// File: rtl/reset_ctrl_sync_debounce.sv
// Multi-flop synchronizer followed by an optional stability filter.
// DEBOUNCE_CYCLES=1 bypasses the filter so the output is the plain synchronizer.
module sync_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES <= 1) begin : g_bypass
            assign dout = sync_s;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

            logic [CNT_W-1:0] cnt;
            logic             db_q;

            // The filtered level flips only after the input disagreed for a full run.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt  <= '0;
                    db_q <= RESET_VAL;
                end else if (sync_s == db_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt  <= '0;
                    db_q <= sync_s;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign dout = db_q;
        end
    endgenerate

endmodule

// File: rtl/reset_ctrl.sv
// Reset sequencer: qualifies PLL lock, stretches reset, and re-asserts it on
// lock loss or a debounced button press. Outputs are all registered.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_FILTER     = 256,
    parameter int HOLD_CYCLES     = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  btn_n,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output state_t                dbg_state
);

    localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic lock_s;
    logic btn_db;
    logic press;

    state_t            state;
    logic [FILT_W-1:0] filt_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(1),
        .RESET_VAL      (1'b0)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (locked),
        .dout (lock_s)
    );

    sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
    ) u_btn_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (btn_n),
        .dout (btn_db)
    );

    assign press     = ~btn_db;
    assign dbg_state = state;

    // sys_rst_n/ready default low each cycle and are raised only for a RUN next state,
    // so they track state on the same edge without a combinational output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            filt_cnt      <= '0;
            hold_cnt      <= '0;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILT_LAST) begin
                        state    <= HOLD;
                        filt_cnt <= '0;
                        hold_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + FILT_W'(1);
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        filt_cnt <= '0;
                    end else if (press) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        hold_cnt  <= '0;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        filt_cnt  <= '0;
                        lock_lost <= 1'b1;
                        if (lock_loss_cnt != LOSS_CNT_MAX) begin
                            lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
                        end
                    end else if (press) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl with small parameters; expected output words
// are queued as stimulus is applied and compared once the DUT has responded.
module tb_reset_ctrl;
    import reset_ctrl_pkg::*;

    localparam int W = 9;

    logic                  clk;
    logic                  rst_n;
    logic                  locked;
    logic                  btn_n;
    logic                  sys_rst_n;
    logic                  ready;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    state_t                dbg_state;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    int           exp_cnt = 0;

    reset_ctrl #(
        .SYNC_STAGES    (2),
        .LOCK_FILTER    (4),
        .HOLD_CYCLES    (8),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .btn_n        (btn_n),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .lock_loss_cnt(lock_loss_cnt),
        .dbg_state    (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pack(input logic [1:0] st, input logic srst, input logic rdy,
                                          input logic lost, input logic [3:0] cnt);
        return {st, srst, rdy, lost, cnt};
    endfunction

    // Driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: push the expectation, let the DUT run, then pop and compare.
    task automatic expect_after(input int n, input string tag, input logic [1:0] st,
                                input logic srst, input logic rdy, input logic lost,
                                input logic [3:0] cnt);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        string        t;
        exp_q.push_back(pack(st, srst, rdy, lost, cnt));
        tag_q.push_back(tag);
        step(n);
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = pack(dbg_state, sys_rst_n, ready, lock_lost, lock_loss_cnt);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed={st,srst,rdy,lost,cnt}=%b expected=%b", t, obs_v, exp_v);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        btn_n  = 1'b1;
        expect_after(3, "reset_state", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd0);

        // Lock-up: RUN after the 14th edge, not the 13th
        rst_n  = 1'b1;
        locked = 1'b1;
        expect_after(13, "lockup_edge12", HOLD, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_after(1, "lockup_edge13", RUN, 1'b1, 1'b1, 1'b0, 4'd0);

        // Lock loss in RUN
        locked = 1'b0;
        expect_after(2, "loss_edge1", RUN, 1'b1, 1'b1, 1'b0, 4'd0);
        exp_cnt = sat_inc(exp_cnt);
        expect_after(1, "loss_edge2", WAIT_LOCK, 1'b0, 1'b0, 1'b1, 4'(exp_cnt));

        // Lock glitch: two-cycle pulse must not qualify
        locked = 1'b1;
        step(2);
        locked = 1'b0;
        expect_after(5, "glitch_no_hold", WAIT_LOCK, 1'b0, 1'b0, 1'b1, 4'(exp_cnt));
        locked = 1'b1;
        expect_after(13, "glitch_relock12", HOLD, 1'b0, 1'b0, 1'b1, 4'(exp_cnt));
        expect_after(1, "glitch_relock13", RUN, 1'b1, 1'b1, 1'b1, 4'(exp_cnt));

        // Simultaneous lock loss and debounced press: loss wins
        btn_n = 1'b0;
        step(3);
        locked = 1'b0;
        expect_after(2, "simul_edge4", RUN, 1'b1, 1'b1, 1'b1, 4'(exp_cnt));
        exp_cnt = sat_inc(exp_cnt);
        expect_after(1, "simul_edge5", WAIT_LOCK, 1'b0, 1'b0, 1'b1, 4'(exp_cnt));
        btn_n = 1'b1;
        step(8);
        locked = 1'b1;
        expect_after(14, "simul_relock", RUN, 1'b1, 1'b1, 1'b1, 4'(exp_cnt));

        // Repeated losses until the counter saturates (17 events in total)
        for (int i = 0; i < 15; i++) begin
            locked = 1'b0;
            exp_cnt = sat_inc(exp_cnt);
            expect_after(3, "repeat_loss", WAIT_LOCK, 1'b0, 1'b0, 1'b1, 4'(exp_cnt));
            locked = 1'b1;
            expect_after(14, "repeat_relock", RUN, 1'b1, 1'b1, 1'b1, 4'(exp_cnt));
        end
        expect_after(0, "loss_saturated", RUN, 1'b1, 1'b1, 1'b1, 4'd15);

        // Button bounce shorter than the debounce window
        for (int i = 0; i < 2; i++) begin
            btn_n = 1'b0;
            step(1);
            btn_n = 1'b1;
            step(1);
        end
        expect_after(6, "bounce_ignored", RUN, 1'b1, 1'b1, 1'b1, 4'd15);

        // Long press: HOLD after debounce, RUN 8 cycles after the release is filtered
        btn_n = 1'b0;
        expect_after(5, "press_edge4", RUN, 1'b1, 1'b1, 1'b1, 4'd15);
        expect_after(1, "press_edge5", HOLD, 1'b0, 1'b0, 1'b1, 4'd15);
        step(4);
        btn_n = 1'b1;
        expect_after(12, "release_edge21", HOLD, 1'b0, 1'b0, 1'b1, 4'd15);
        expect_after(1, "release_edge22", RUN, 1'b1, 1'b1, 1'b1, 4'd15);

        // Async reset in the middle of HOLD
        locked = 1'b0;
        expect_after(3, "pre_hold_loss", WAIT_LOCK, 1'b0, 1'b0, 1'b1, 4'd15);
        locked = 1'b1;
        expect_after(8, "in_hold", HOLD, 1'b0, 1'b0, 1'b1, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        expect_after(0, "async_reset", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        rst_n = 1'b1;
        expect_after(13, "after_reset12", HOLD, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_after(1, "after_reset13", RUN, 1'b1, 1'b1, 1'b0, 4'd0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_ctrl.md
Name: reset_ctrl

Overview:
- Reset sequencer directly downstream of the PLL wrapper.
- Runs on the PLL output clock and consumes the PLL `locked` flag, an external async reset and a raw push-button.
- Drives a glitch-free, synchronously released system reset for the 6502 core, memories and peripherals.
- Holds the system in reset until lock is stable for a programmable time, and re-asserts reset on lock loss or button press.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronizers for `locked` and `btn_n`; legal range 2..4.
- LOCK_FILTER, 256: consecutive cycles the synchronized `locked` must be 1 before leaving WAIT_LOCK; minimum 1.
- HOLD_CYCLES, 4096: cycles reset stays asserted after lock is qualified or after a button release; minimum 1.
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before the debounced button changes state; minimum 1.

Ports:
- clk, input, 1: PLL output clock; all logic is on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low (power-on / board reset).
- locked, input, 1: PLL lock flag, treated as asynchronous.
- btn_n, input, 1: raw user reset button, active-low, asynchronous, bouncy.
- sys_rst_n, output, 1: system reset, active-low; asserts asynchronously with rst_n and releases synchronously to clk.
- ready, output, 1: high exactly when state==RUN; registered.
- lock_lost, output, 1: sticky flag, set on any lock loss seen in RUN; cleared only by rst_n.
- lock_loss_cnt, output, 4: count of lock-loss events in RUN; saturates at 15.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low; every flop clears asynchronously on rst_n=0.
- Values while rst_n=0:
  - state=WAIT_LOCK.
  - All counters 0; synchronizer flops 0, except the btn synchronizer, which resets to 1 (released).
  - debounced button = released.
  - sys_rst_n=0, ready=0, lock_lost=0, lock_loss_cnt=0.
- Synchronizers:
  - lock_s = `locked` after SYNC_STAGES flops; btn_s = `btn_n` after SYNC_STAGES flops.
  - A level held before edge 0 appears on the synchronized signal after edge SYNC_STAGES-1.
- Debouncer:
  - btn_db changes only after btn_s differs from btn_db for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears whenever btn_s equals btn_db.
  - press = btn_db low.
- State WAIT_LOCK:
  - filt_cnt increments on each cycle with lock_s=1 and clears on lock_s=0.
  - On the cycle filt_cnt==LOCK_FILTER-1 and lock_s=1: go to HOLD, hold_cnt<=0.
- State HOLD:
  - hold_cnt increments each cycle.
  - lock_s=0 → WAIT_LOCK, filt_cnt<=0. This has priority over everything else.
  - press → hold_cnt<=0 and stay in HOLD; the count restarts after release.
  - hold_cnt==HOLD_CYCLES-1 with no press → RUN.
- State RUN:
  - lock_s=0 → WAIT_LOCK, filt_cnt<=0, lock_lost<=1, lock_loss_cnt increments (saturating at 15).
  - Otherwise press → HOLD, hold_cnt<=0.
  - Lock loss wins over a simultaneous press.
- Output timing: sys_rst_n and ready are flops updated on the same edge as state, so both are 1 from the first cycle state==RUN. No combinational path from any input to any output.
- Counter widths: each counter is sized as clog2 of its terminal count and must never wrap.
- Mid-operation reset: rst_n asserted at any time forces sys_rst_n=0 immediately (async). Release always restarts from WAIT_LOCK.

Decomposition:
- Package reset_ctrl_pkg:
  - state enum {WAIT_LOCK, HOLD, RUN}, 2-bit encoding.
  - LOSS_CNT_W=4 and LOSS_CNT_MAX=15.
- Sub-module sync_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES, RESET_VAL):
  - Synchronizer plus stability counter.
  - Instantiated for btn_n.
  - For `locked`, the plain synchronizer is used with debounce bypassed (DEBOUNCE_CYCLES=1).

Test Plan (bench parameters SYNC_STAGES=2, LOCK_FILTER=4, HOLD_CYCLES=8, DEBOUNCE_CYCLES=3):
- Lock-up: rst_n released, locked=1 set before edge 0 → sys_rst_n and ready rise after the 14th rising edge (edges 0..13); lock_lost=0.
- Lock glitch: locked pulsed 1 for 2 cycles, then 0, then 1 held → no HOLD entry during the pulse; the 14-edge count restarts from the final rise.
- Lock loss in RUN: locked→0 before edge 0 → sys_rst_n=0 after the 3rd edge, lock_lost=1, lock_loss_cnt=1. Repeat 17 loss events → lock_loss_cnt holds 15.
- Button in RUN: btn_n bounces 0/1 for 2 cycles → no effect. btn_n held 0 for 10 cycles then released → sys_rst_n=0 after debounce; RUN is re-entered 8 cycles after btn_db returns high.
- Simultaneous: in RUN, locked falls and the debounced press occurs on the same cycle → state WAIT_LOCK, lock_loss_cnt increments.
- Async reset: rst_n pulsed low mid-HOLD with no clock edge → sys_rst_n=0 and all counters 0 immediately; full 14-edge sequence after release.
